// File: rtl/decoder_scan_pkg.sv
// decoder_scan_pkg: command modes and controller states for decoder_scan
package decoder_scan_pkg;
  typedef enum logic [1:0] {
    MODE_DIRECT    = 2'b00,
    MODE_SCAN_UP   = 2'b01,
    MODE_SCAN_DOWN = 2'b10,
    MODE_OFF       = 2'b11
  } mode_t;
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HOLD,
    ST_SCAN
  } state_t;
endpackage

// File: rtl/decoder_scan_onehot_dec.sv
// onehot_dec: combinational ADDR_W to 2**ADDR_W one-hot decoder
module onehot_dec #(
  parameter int ADDR_W = 5
) (
  input  logic [ADDR_W-1:0]      addr,
  output logic [2**ADDR_W-1:0]   onehot
);
  assign onehot = {{(2**ADDR_W-1){1'b0}}, 1'b1} << addr;
endmodule

// File: rtl/decoder_scan.sv
// decoder_scan: registered one-hot decoder with direct and up/down scan modes
module decoder_scan
  import decoder_scan_pkg::*;
#(
  parameter int ADDR_W  = 5,
  parameter int DWELL_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [1:0]           in_mode,
  input  logic [ADDR_W-1:0]    in_addr,
  input  logic [DWELL_W-1:0]   in_dwell,
  output logic [2**ADDR_W-1:0] out_onehot,
  output logic [ADDR_W-1:0]    out_addr,
  output logic                 out_valid,
  output logic                 wrap
);
  localparam int OUT_W = 2**ADDR_W;
  state_t             state;
  mode_t              mode;
  logic [DWELL_W-1:0] cnt, dwell;
  logic               up, accept, step, nxt_valid;
  logic [ADDR_W-1:0]  step_addr, nxt_addr;
  logic [OUT_W-1:0]   dec;
  assign mode      = mode_t'(in_mode);
  assign in_ready  = state != ST_SCAN || cnt == '0;
  assign accept    = in_valid && in_ready;
  // a command accepted on a step boundary suppresses the step
  assign step      = !accept && state == ST_SCAN && cnt == '0;
  assign step_addr = up ? out_addr + 1'b1 : out_addr - 1'b1;
  assign nxt_addr  = accept ? (mode == MODE_OFF ? '0 : in_addr) : step ? step_addr : out_addr;
  assign nxt_valid = accept ? mode != MODE_OFF : out_valid;
  onehot_dec #(.ADDR_W(ADDR_W)) u_dec (
    .addr   (nxt_addr),
    .onehot (dec)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      dwell      <= '0;
      up         <= 1'b0;
      out_addr   <= '0;
      out_valid  <= 1'b0;
      out_onehot <= '0;
      wrap       <= 1'b0;
    end else begin
      out_addr   <= nxt_addr;
      out_valid  <= nxt_valid;
      out_onehot <= nxt_valid ? dec : '0;
      wrap       <= step && (up ? &out_addr : ~|out_addr);
      if (accept) begin
        state <= mode == MODE_OFF ? ST_IDLE : mode == MODE_DIRECT ? ST_HOLD : ST_SCAN;
        cnt   <= (mode == MODE_SCAN_UP || mode == MODE_SCAN_DOWN) ? in_dwell : '0;
        dwell <= in_dwell;
        up    <= mode == MODE_SCAN_UP;
      end else if (state == ST_SCAN)
        cnt <= cnt == '0 ? dwell : cnt - 1'b1;
    end
endmodule

// File: tb/tb_decoder_scan.sv
// tb_decoder_scan: table-driven and scoreboard checks of decoder_scan
module tb_decoder_scan;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  in_mode = 2'b11;
  logic [4:0]  in_addr = '0;
  logic [7:0]  in_dwell = '0;
  logic [31:0] out_onehot;
  logic [4:0]  out_addr;
  logic        out_valid;
  logic        wrap;
  int          checks = 0;
  int          errors = 0;

  typedef struct {
    logic [31:0] oh;
    logic [4:0]  addr;
    logic        v;
    logic        w;
    logic        rdy;
  } exp_t;

  typedef struct {
    logic [1:0]  mode;
    logic [4:0]  addr;
    logic [31:0] oh;
    logic [4:0]  eaddr;
    logic        v;
  } vec_t;

  exp_t q[$];

  decoder_scan dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_mode    (in_mode),
    .in_addr    (in_addr),
    .in_dwell   (in_dwell),
    .out_onehot (out_onehot),
    .out_addr   (out_addr),
    .out_valid  (out_valid),
    .wrap       (wrap)
  );

  always #5 clk = ~clk;

  task automatic push(input logic [31:0] oh, input logic [4:0] a, input logic v, input logic w, input logic rdy);
    exp_t e;
    e.oh = oh; e.addr = a; e.v = v; e.w = w; e.rdy = rdy;
    q.push_back(e);
  endtask

  task automatic push_addr(input logic [4:0] a, input logic w, input logic rdy);
    logic [31:0] one;
    one = 32'h1;
    push(one << a, a, 1'b1, w, rdy);
  endtask

  task automatic check_now(input string name);
    exp_t e;
    checks++;
    if (q.size() == 0) begin
      errors++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      e = q.pop_front();
      if (out_onehot !== e.oh || out_addr !== e.addr || out_valid !== e.v || wrap !== e.w || in_ready !== e.rdy) begin
        errors++;
        $display("FAIL %s @%0t: got oh=%h addr=%0d v=%b w=%b rdy=%b, expected oh=%h addr=%0d v=%b w=%b rdy=%b",
                 name, $time, out_onehot, out_addr, out_valid, wrap, in_ready, e.oh, e.addr, e.v, e.w, e.rdy);
      end
    end
  endtask

  task automatic tick(input string name);
    @(posedge clk);
    #1;
    check_now(name);
  endtask

  task automatic cmd(input logic [1:0] m, input logic [4:0] a, input logic [7:0] d);
    in_valid = 1'b1; in_mode = m; in_addr = a; in_dwell = d;
  endtask

  vec_t vecs[6];

  initial begin
    vecs[0] = '{2'b00, 5'd5,  32'h0000_0020, 5'd5,  1'b1};
    vecs[1] = '{2'b00, 5'd0,  32'h0000_0001, 5'd0,  1'b1};
    vecs[2] = '{2'b00, 5'd31, 32'h8000_0000, 5'd31, 1'b1};
    vecs[3] = '{2'b11, 5'd9,  32'h0000_0000, 5'd0,  1'b0};
    vecs[4] = '{2'b00, 5'd17, 32'h0002_0000, 5'd17, 1'b1};
    vecs[5] = '{2'b00, 5'd5,  32'h0000_0020, 5'd5,  1'b1};

    #3;
    push(32'h0, 5'd0, 1'b0, 1'b0, 1'b1);
    check_now("reset");
    @(negedge clk);
    rst_n = 1'b1;
    push(32'h0, 5'd0, 1'b0, 1'b0, 1'b1);
    tick("idle");

    // direct/off table: command, then a few stable cycles
    for (int i = 0; i < 6; i++) begin
      cmd(vecs[i].mode, vecs[i].addr, 8'd0);
      push(vecs[i].oh, vecs[i].eaddr, vecs[i].v, 1'b0, 1'b1);
      tick("table_cmd");
      in_valid = 1'b0;
      for (int k = 0; k < 3; k++) begin
        push(vecs[i].oh, vecs[i].eaddr, vecs[i].v, 1'b0, 1'b1);
        tick("table_hold");
      end
    end

    for (int k = 0; k < 100; k++) begin
      push(32'h0000_0020, 5'd5, 1'b1, 1'b0, 1'b1);
      tick("direct5_stable");
    end

    // scan up from 30, dwell 2, across the wrap
    cmd(2'b01, 5'd30, 8'd2);
    for (int i = 0; i < 10; i++) begin
      push_addr(5'(30 + i / 3), (i / 3 == 2) && (i % 3 == 0), i % 3 == 2);
      tick("scan_up");
      in_valid = 1'b0;
    end

    // held scan-down command lands only on the step boundary
    cmd(2'b10, 5'd1, 8'd0);
    push_addr(5'd1, 1'b0, 1'b0);
    tick("wait_ready0");
    push_addr(5'd1, 1'b0, 1'b1);
    tick("wait_ready1");
    push_addr(5'd1, 1'b0, 1'b1);
    tick("scan_down_load");
    in_valid = 1'b0;
    push_addr(5'd0, 1'b0, 1'b1);
    tick("scan_down_0");
    push_addr(5'd31, 1'b1, 1'b1);
    tick("scan_down_31");
    push_addr(5'd30, 1'b0, 1'b1);
    tick("scan_down_30");
    push_addr(5'd29, 1'b0, 1'b1);
    tick("scan_down_29");

    // direct 7 held during dwell-3 scan: no step on the accepting edge
    cmd(2'b01, 5'd10, 8'd3);
    push_addr(5'd10, 1'b0, 1'b0);
    tick("scan3_load");
    cmd(2'b00, 5'd7, 8'd0);
    push_addr(5'd10, 1'b0, 1'b0);
    tick("scan3_c2");
    push_addr(5'd10, 1'b0, 1'b0);
    tick("scan3_c1");
    push_addr(5'd10, 1'b0, 1'b1);
    tick("scan3_c0");
    push(32'h0000_0080, 5'd7, 1'b1, 1'b0, 1'b1);
    tick("direct7_win");
    in_valid = 1'b0;
    push(32'h0000_0080, 5'd7, 1'b1, 1'b0, 1'b1);
    tick("direct7_hold");

    // off from hold
    cmd(2'b11, 5'd12, 8'd0);
    push(32'h0, 5'd0, 1'b0, 1'b0, 1'b1);
    tick("off");
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      push(32'h0, 5'd0, 1'b0, 1'b0, 1'b1);
      tick("off_hold");
    end

    // asynchronous reset mid-scan
    cmd(2'b01, 5'd3, 8'd5);
    push_addr(5'd3, 1'b0, 1'b0);
    tick("rst_scan_a");
    in_valid = 1'b0;
    push_addr(5'd3, 1'b0, 1'b0);
    tick("rst_scan_b");
    #2;
    rst_n = 1'b0;
    #1;
    push(32'h0, 5'd0, 1'b0, 1'b0, 1'b1);
    check_now("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      push(32'h0, 5'd0, 1'b0, 1'b0, 1'b1);
      tick("post_reset_idle");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/decoder_scan.md
# decoder_scan

Parametrised, registered one-hot decoder with an autonomous scan engine. It converts an `ADDR_W`-bit address into a `2**ADDR_W`-bit one-hot select, either statically (direct mode) or by stepping through addresses up or down with a programmable dwell time. It serves as the select/strobe generator for row-scanned and time-multiplexed peripherals, accepting commands from a controller over a valid/ready handshake.

## Interface
- `ADDR_W`, default 5: address width; output width `OUT_W = 2**ADDR_W` is derived, not a parameter.
- `DWELL_W`, default 8: width of the dwell field; each scan step lasts `dwell+1` cycles.
- `clk` input 1: single clock; all state changes on rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `in_valid` input 1: command present.
- `in_ready` output 1: command can be accepted this cycle.
- `in_mode` input 2: 00 DIRECT, 01 SCAN_UP, 10 SCAN_DOWN, 11 OFF.
- `in_addr` input ADDR_W: direct address, or scan start address.
- `in_dwell` input DWELL_W: dwell for scan modes; ignored otherwise.
- `out_onehot` output OUT_W: registered one-hot select; all zero when not valid.
- `out_addr` output ADDR_W: registered address currently decoded.
- `out_valid` output 1: `out_onehot` holds exactly one set bit.
- `wrap` output 1: one-cycle pulse on scan wrap-around.

## Operation
- States: IDLE (outputs zero), HOLD (static decode), SCAN (stepping). Reset enters IDLE.
- Command accepted on a rising edge with `in_valid && in_ready`; `in_mode`, `in_addr`, `in_dwell` sampled at that edge.
- DIRECT: state HOLD, `out_addr = in_addr`, `out_onehot = 1 << in_addr`, `out_valid = 1`; held until the next command.
- SCAN_UP/SCAN_DOWN: state SCAN, first displayed address `in_addr`, dwell counter loaded with `in_dwell`. Counter decrements each cycle; when it is 0 the next edge steps `out_addr` by +1 (up) or −1 (down), modulo `OUT_W`, and reloads the counter.
- Wrap: up-scan step 31→0 (generally `OUT_W-1`→0) or down-scan step 0→`OUT_W-1` sets `wrap` for exactly the first cycle of the new address. Never asserted in HOLD/IDLE or on command load.
- OFF: state IDLE, `out_onehot = 0`, `out_valid = 0`, `out_addr = 0`.
- `in_ready`: 1 in IDLE and HOLD; in SCAN, 1 only while the dwell counter is 0 (last cycle of a step). Mode changes therefore land on step boundaries. With `dwell = 0`, `in_ready` is constantly 1.
- Simultaneous step and command accept: the command wins. No step is taken and `wrap` is not pulsed.
- Invariant: `out_valid` implies `out_onehot == 1 << out_addr`; `!out_valid` implies `out_onehot == 0`.

## Timing
- Reset values: `out_onehot = 0`, `out_addr = 0`, `out_valid = 0`, `wrap = 0`, dwell counter 0, state IDLE. `in_ready = 1` (combinational from state).
- Reset assertion clears all registers immediately, including mid-scan, without waiting for a clock edge. Operation resumes on the first edge after deassertion.
- Command latency: new outputs visible in the cycle after the accepting edge (1 cycle).
- Scan period: each address is displayed for exactly `dwell+1` cycles. A full scan cycle is `OUT_W*(dwell+1)` cycles.
- `in_ready` is combinational from state and counter only; no combinational path from `in_valid`.

## Structure
- Package `decoder_scan_pkg`: mode enum (`MODE_DIRECT`, `MODE_SCAN_UP`, `MODE_SCAN_DOWN`, `MODE_OFF`) and state enum (`ST_IDLE`, `ST_HOLD`, `ST_SCAN`).
- Sub-module `onehot_dec`: purely combinational, parametrised `ADDR_W` → `2**ADDR_W` decoder. Its output is registered in `decoder_scan`.

## Test plan
- Assert `rst_n` low mid-scan with `dwell = 5` → all outputs 0 within the same cycle; after release, `in_ready = 1` and state is IDLE.
- DIRECT `addr = 5` → next cycle `out_onehot = 32'h0000_0020`, `out_addr = 5`, `out_valid = 1`; outputs stable for 100 cycles.
- SCAN_UP `addr = 30`, `dwell = 2` → `out_addr` is 30 ×3 cycles, then 31 ×3, then 0 with `wrap = 1` only on its first cycle, then 1.
- SCAN_DOWN `addr = 1`, `dwell = 0` → `out_addr` sequence 1, 0, 31 (with `wrap`), 30; `in_ready` stays 1 throughout.
- During SCAN with `dwell = 3`, hold `in_valid` with DIRECT `addr = 7` → accepted only on the cycle where `in_ready = 1`; no step on that edge; then `out_onehot = 32'h0000_0080`.
- OFF command from HOLD → next cycle `out_onehot = 0`, `out_valid = 0`, `out_addr = 0`; `wrap` never asserted.
